alu_seq: RTL

- Parametrised, registered successor to the team's 16-bit combinational ALU.
- Keeps the same operand controls: invA, invB, Cin, sign, and the 3-bit Op map.
- Adds a valid/ready handshake on input and output, plus an output holding register.
- Adds an optional iterative shift-add multiplier, so the block can sit between decode and writeback as a multi-cycle execute unit.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle for alu_seq
// master drives operands and out_ready; slave (the ALU) drives in_ready and the result.
interface alu_seq_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [2:0]       Op;
  logic             invA;
  logic             invB;
  logic             sign;
  logic             mul;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Out;
  logic             OFL;
  logic             Zero;
  modport master (
    output in_valid, A, B, Cin, Op, invA, invB, sign, mul, out_ready,
    input  in_ready, out_valid, Out, OFL, Zero
  );
  modport slave (
    input  in_valid, A, B, Cin, Op, invA, invB, sign, mul, out_ready,
    output in_ready, out_valid, Out, OFL, Zero
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake and optional iterative shift-add multiplier
// Ports: clk, rst (sync, active-high); bus (alu_seq_if.slave): operands A/B/Cin/Op/invA/invB/sign/mul
// with in_valid/in_ready, result Out/OFL/Zero with out_valid/out_ready.
// Macro ALU_SEQ_MUL_EN adds the MUL state, accumulator and multiply path; undefined, mul is ignored.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  logic [WIDTH-1:0] ain, bin, res, out_q, out_d;
  logic [SHW-1:0]   sh;
  logic [SHW:0]     rsh;
  logic [WIDTH:0]   sum;
  logic             ofl, ofl_q, ofl_d, zero_q, zero_d, ov_q, ov_d, idle, accept, mul_go;
  assign ain = bus.invA ? ~bus.A : bus.A;
  assign bin = bus.invB ? ~bus.B : bus.B;
  assign sh  = bin[SHW-1:0];
  // complementary shift for rotates; equals WIDTH when sh is 0, which shifts everything out
  assign rsh = (SHW+1)'(WIDTH) - {1'b0, sh};
  assign sum = {1'b0, ain} + {1'b0, bin} + {{WIDTH{1'b0}}, bus.Cin};
  always_comb begin
    res = sum[WIDTH-1:0];
    ofl = 1'b0;
    case (bus.Op)
      3'b000: res = (ain << sh) | (ain >> rsh);
      3'b001: res = ain << sh;
      3'b010: res = (ain >> sh) | (ain << rsh);
      3'b011: res = ain >> sh;
      3'b100: ofl = bus.sign ? (ain[WIDTH-1] == bin[WIDTH-1]) && (sum[WIDTH-1] != ain[WIDTH-1]) : sum[WIDTH];
      3'b101: res = ain | bin;
      3'b110: res = ain ^ bin;
      default: res = ain & bin;
    endcase
  end
  assign bus.in_ready = idle && (!ov_q || bus.out_ready) && !rst;
  assign accept = bus.in_valid && bus.in_ready;
`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;
  localparam logic [2*WIDTH-1:0] LIM = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mc_q, mc_d, acc_nx;
  logic [WIDTH-1:0]   mb_q, mb_d, ma, mbv, prod;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               neg_q, neg_d, sgn_q, sgn_d, mofl;
  assign idle   = state_q == IDLE;
  assign mul_go = accept && bus.mul;
  // magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned
  assign ma     = bus.sign && ain[WIDTH-1] ? -ain : ain;
  assign mbv    = bus.sign && bin[WIDTH-1] ? -bin : bin;
  assign acc_nx = acc_q + (mb_q[0] ? mc_q : '0);
  assign prod   = neg_q ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
  // signed fit: magnitude up to 2^(WIDTH-1) when negative, one less when positive
  assign mofl   = sgn_q ? (neg_q ? acc_nx > LIM : acc_nx >= LIM) : |acc_nx[2*WIDTH-1:WIDTH];
`else
  assign idle   = 1'b1;
  assign mul_go = 1'b0;
`endif
  always_comb begin
    out_d  = out_q;
    ofl_d  = ofl_q;
    zero_d = zero_q;
    ov_d   = ov_q && !bus.out_ready;
    if (accept && !mul_go) begin
      out_d  = res;
      ofl_d  = ofl;
      zero_d = res == '0;
      ov_d   = 1'b1;
    end
`ifdef ALU_SEQ_MUL_EN
    state_d = state_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    mb_d    = mb_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    if (mul_go) begin
      state_d = MUL;
      acc_d   = '0;
      mc_d    = {{WIDTH{1'b0}}, ma};
      mb_d    = mbv;
      cnt_d   = '0;
      neg_d   = bus.sign && (ain[WIDTH-1] ^ bin[WIDTH-1]);
      sgn_d   = bus.sign;
      ov_d    = 1'b0;
    end
    if (state_q == MUL) begin
      acc_d = acc_nx;
      mc_d  = mc_q << 1;
      mb_d  = mb_q >> 1;
      cnt_d = cnt_q + 1'b1;
      // WIDTH is a power of two, so the last step is the all-ones count
      if (&cnt_q) begin
        state_d = IDLE;
        out_d   = prod;
        ofl_d   = mofl;
        zero_d  = prod == '0;
        ov_d    = 1'b1;
      end
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      ofl_q  <= 1'b0;
      zero_q <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      out_q  <= out_d;
      ofl_q  <= ofl_d;
      zero_q <= zero_d;
      ov_q   <= ov_d;
    end
  end
`ifdef ALU_SEQ_MUL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mc_q    <= '0;
      mb_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      mb_q    <= mb_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
    end
  end
`endif
  assign bus.Out       = out_q;
  assign bus.OFL       = ofl_q;
  assign bus.Zero      = zero_q;
  assign bus.out_valid = ov_q;
endmodule
